instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory load port: turns a byte stream (e.g. UART RX) into 32-bit words and drives the memory write interface (write enable, data, byte address).
- Sits between the debug/UART receiver and the fetch stage's instruction RAM.
- Holds the CPU halted while loading; ends on a terminator (HALT) word or on memory overflow.

---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_assembler.sv | 39 +++
 rtl/instr_mem_loader.sv | 141 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t           : loader FSM states
//   DEFAULT_HALT_WORD : terminator instruction; also used by the instruction decoder
//   BYTES_PER_WORD    : bytes per instruction word
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_OVERFLOW
    } state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD    = 4;

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into 32-bit words, MSB first.
// Ports:
//   clk, i_rst_n : clock, synchronous active-low reset
//   clear        : discard any partial word
//   byte_valid   : accept byte_data this cycle
//   byte_data    : incoming byte
//   word_valid   : high in the cycle the 4th byte is accepted
//   word         : assembled word, valid while word_valid is high
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    // Only the three earlier bytes need storing; the fourth is taken straight
    // from the input so the word is available in the cycle it completes.
    logic [23:0] shreg;

    assign word       = {shreg, byte_data};
    assign word_valid = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!i_rst_n || clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (byte_valid) begin
            shreg    <= word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory load port writer: turns received bytes into 32-bit words
// and writes them to consecutive word addresses, holding the CPU meanwhile.
// A load ends on HALT_WORD (written, then o_done) or when the last memory
// slot has been written (o_overflow).
// Ports:
//   clk, i_rst_n  : clock, synchronous active-low reset
//   i_load_start  : one-cycle pulse, starts/restarts a session
//   i_rx_data/valid: byte stream
//   o_we, o_instr_data, o_addr : memory write port (one pulse per word)
//   o_cpu_hold    : fetch halt while receiving/writing
//   o_done, o_overflow : session end flags (levels)
//   o_word_count  : words written this session
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no session since reset; bytes ignored
// RECV     | collecting bytes of the next word
// WRITE    | single cycle: o_we asserted for the assembled word
// DONE     | HALT_WORD written; o_done held
// OVERFLOW | last slot written without HALT_WORD; o_overflow held
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int          NB_ADDR   = 8,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_load_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_we,
    output logic [31:0]        o_instr_data,
    output logic [NB_ADDR-1:0] o_addr,
    output logic               o_cpu_hold,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR-2:0] o_word_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};

    state_t             state, state_nxt;
    logic [NB_ADDR-1:0] addr;
    logic [NB_ADDR-2:0] word_count;
    logic [31:0]        instr_data;
    logic               done, overflow;

    logic               accept_byte;
    logic               word_valid;
    logic [31:0]        word;
    logic               is_halt;
    logic               last_slot;

    assign is_halt   = (instr_data == HALT_WORD);
    assign last_slot = (addr == LAST_ADDR);

    // A byte arriving in WRITE belongs to the next word, but only if the
    // session continues. A start in the same cycle drops the byte.
    assign accept_byte = i_rx_valid && !i_load_start &&
                         ((state == ST_RECV) ||
                          ((state == ST_WRITE) && !is_halt && !last_slot));

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .clear      (i_load_start),
        .byte_valid (accept_byte),
        .byte_data  (i_rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_load_start) begin
            state_nxt = ST_RECV;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = ST_IDLE;
                ST_RECV:     if (word_valid) state_nxt = ST_WRITE;
                ST_WRITE: begin
                    if (is_halt)        state_nxt = ST_DONE;
                    else if (last_slot) state_nxt = ST_OVERFLOW;
                    else                state_nxt = ST_RECV;
                end
                ST_DONE:     state_nxt = ST_DONE;
                ST_OVERFLOW: state_nxt = ST_OVERFLOW;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            addr       <= '0;
            word_count <= '0;
            instr_data <= 32'd0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (word_valid) begin
                instr_data <= word;
            end
            // A restart overrides the bookkeeping of a concurrent WRITE; its
            // o_we still goes out because o_we is decoded from the current state.
            if (i_load_start) begin
                addr       <= '0;
                word_count <= '0;
                done       <= 1'b0;
                overflow   <= 1'b0;
            end else if (state == ST_WRITE) begin
                word_count <= word_count + (NB_ADDR-1)'(1);
                if (is_halt) begin
                    done <= 1'b1;
                end else if (last_slot) begin
                    overflow <= 1'b1;
                end else begin
                    addr <= addr + NB_ADDR'(BYTES_PER_WORD);
                end
            end
        end
    end

    assign o_we         = (state == ST_WRITE);
    assign o_instr_data = instr_data;
    assign o_addr       = addr;
    assign o_cpu_hold   = (state == ST_RECV) || (state == ST_WRITE);
    assign o_done       = done;
    assign o_overflow   = overflow;
    assign o_word_count = word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int          NB_ADDR   = 4;
    localparam int          CAP_BYTES = 1 << NB_ADDR;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    logic               clk;
    logic               i_rst_n;
    logic               i_load_start;
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic               o_we;
    logic [31:0]        o_instr_data;
    logic [NB_ADDR-1:0] o_addr;
    logic               o_cpu_hold;
    logic               o_done;
    logic               o_overflow;
    logic [NB_ADDR-2:0] o_word_count;

    instr_mem_loader #(.NB_ADDR(NB_ADDR), .HALT_WORD(HALT)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_load_start (i_load_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_we         (o_we),
        .o_instr_data (o_instr_data),
        .o_addr       (o_addr),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a session collects accepted bytes in a queue; every
    // fourth byte yields a word that is written in the following cycle.
    logic [7:0]  m_bytes[$];
    logic        m_active, m_pend, m_done, m_ovf;
    int          m_cnt, m_addr;
    logic [31:0] m_data;

    task automatic model_step(input logic rst_n, input logic s, input logic v, input logic [7:0] b);
        if (!rst_n) begin
            m_bytes.delete();
            m_active = 0; m_pend = 0; m_done = 0; m_ovf = 0;
            m_cnt = 0; m_addr = 0; m_data = 0;
        end else if (s) begin
            m_bytes.delete();
            m_active = 1; m_pend = 0; m_done = 0; m_ovf = 0;
            m_cnt = 0; m_addr = 0;
        end else begin
            if (m_pend) begin
                m_cnt++;
                if (m_data == HALT) begin
                    m_done = 1; m_active = 0;
                end else if (m_addr == CAP_BYTES - 4) begin
                    m_ovf = 1; m_active = 0;
                end else begin
                    m_addr += 4;
                end
                m_pend = 0;
            end
            if (v && m_active) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_pend = 1;
                    m_bytes.delete();
                end
            end
        end
    endtask

    typedef struct {
        logic [NB_ADDR-1:0] a;
        logic [31:0]        d;
    } wr_t;
    wr_t wlog[$];

    task automatic check_model();
        chk("we", o_we, m_pend);
        if (m_pend) chk("addr", 32'(o_addr), m_addr);
        chk("data", o_instr_data, m_data);
        chk("hold", o_cpu_hold, m_active);
        chk("done", o_done, m_done);
        chk("overflow", o_overflow, m_ovf);
        chk("word_count", 32'(o_word_count), m_cnt);
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] b);
        i_rst_n = r; i_load_start = s; i_rx_valid = v; i_rx_data = b;
        @(posedge clk);
        model_step(r, s, v, b);
        #1;
        check_model();
        if (o_we) wlog.push_back('{a: o_addr, d: o_instr_data});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 0, 8'h00);
    endtask

    task automatic chk_log(input string name, input wr_t exp[$]);
        chk({name, "_nwrites"}, wlog.size(), exp.size());
        for (int k = 0; k < exp.size() && k < wlog.size(); k++) begin
            chk({name, "_waddr"}, 32'(wlog[k].a), 32'(exp[k].a));
            chk({name, "_wdata"}, wlog[k].d, exp[k].d);
        end
    endtask

    typedef struct {
        logic        s, v;
        logic [7:0]  b;
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        logic        hold, done, ovf;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] b, logic we, logic [3:0] a,
                                logic [31:0] d, logic hold, logic done, logic ovf, logic [2:0] cnt);
        vec_t t;
        t.s = s; t.v = v; t.b = b; t.we = we; t.a = a; t.d = d;
        t.hold = hold; t.done = done; t.ovf = ovf; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl[11];
    wr_t  exp_q[$];
    logic r_v, s_v, v_v;
    logic [7:0] b_v;

    initial begin
        i_rst_n = 0; i_load_start = 0; i_rx_valid = 0; i_rx_data = 0;
        model_step(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", o_we, 0);
        chk("rst_data", o_instr_data, 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_hold", o_cpu_hold, 0);
        chk("rst_done", o_done, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_count", 32'(o_word_count), 0);

        // Bytes without a start are ignored.
        for (int k = 0; k < 6; k++) drive(1, 0, 1, 8'(8'hA0 + k));
        exp_q.delete();
        chk_log("idle", exp_q);

        // Single word followed by HALT, expected values straight from the table.
        tbl[0]  = mk(1, 0, 8'h00, 0, 4'h0, 32'h0,        1, 0, 0, 3'd0);
        tbl[1]  = mk(0, 1, 8'h12, 0, 4'h0, 32'h0,        1, 0, 0, 3'd0);
        tbl[2]  = mk(0, 1, 8'h34, 0, 4'h0, 32'h0,        1, 0, 0, 3'd0);
        tbl[3]  = mk(0, 1, 8'h56, 0, 4'h0, 32'h0,        1, 0, 0, 3'd0);
        tbl[4]  = mk(0, 1, 8'h78, 1, 4'h0, 32'h12345678, 1, 0, 0, 3'd0);
        tbl[5]  = mk(0, 1, 8'hFF, 0, 4'h4, 32'h12345678, 1, 0, 0, 3'd1);
        tbl[6]  = mk(0, 1, 8'hFF, 0, 4'h4, 32'h12345678, 1, 0, 0, 3'd1);
        tbl[7]  = mk(0, 1, 8'hFF, 0, 4'h4, 32'h12345678, 1, 0, 0, 3'd1);
        tbl[8]  = mk(0, 1, 8'hFF, 1, 4'h4, 32'hFFFFFFFF, 1, 0, 0, 3'd1);
        tbl[9]  = mk(0, 0, 8'h00, 0, 4'h4, 32'hFFFFFFFF, 0, 1, 0, 3'd2);
        tbl[10] = mk(0, 1, 8'h55, 0, 4'h4, 32'hFFFFFFFF, 0, 1, 0, 3'd2);
        for (int k = 0; k < 11; k++) begin
            drive(1, tbl[k].s, tbl[k].v, tbl[k].b);
            chk("tbl_we", o_we, tbl[k].we);
            if (tbl[k].we) chk("tbl_addr", 32'(o_addr), 32'(tbl[k].a));
            chk("tbl_data", o_instr_data, tbl[k].d);
            chk("tbl_hold", o_cpu_hold, tbl[k].hold);
            chk("tbl_done", o_done, tbl[k].done);
            chk("tbl_overflow", o_overflow, tbl[k].ovf);
            chk("tbl_count", 32'(o_word_count), 32'(tbl[k].cnt));
        end

        // Back-to-back bytes, including one during the WRITE cycle.
        wlog.delete();
        drive(1, 1, 0, 8'h00);
        for (int k = 1; k <= 8; k++) drive(1, 0, 1, 8'(k));
        idle(2);
        exp_q.delete();
        exp_q.push_back('{a: 4'h0, d: 32'h01020304});
        exp_q.push_back('{a: 4'h4, d: 32'h05060708});
        chk_log("b2b", exp_q);

        // Restart mid-word discards the partial word.
        wlog.delete();
        drive(1, 1, 0, 8'h00);
        drive(1, 0, 1, 8'hAA);
        drive(1, 0, 1, 8'hBB);
        drive(1, 1, 0, 8'h00);
        drive(1, 0, 1, 8'h11);
        drive(1, 0, 1, 8'h22);
        drive(1, 0, 1, 8'h33);
        drive(1, 0, 1, 8'h44);
        idle(2);
        exp_q.delete();
        exp_q.push_back('{a: 4'h0, d: 32'h11223344});
        chk_log("restart", exp_q);

        // Overflow: four words fill the memory, later bytes are ignored.
        wlog.delete();
        drive(1, 1, 0, 8'h00);
        for (int k = 1; k <= 20; k++) drive(1, 0, 1, 8'(k));
        idle(2);
        exp_q.delete();
        exp_q.push_back('{a: 4'h0, d: 32'h01020304});
        exp_q.push_back('{a: 4'h4, d: 32'h05060708});
        exp_q.push_back('{a: 4'h8, d: 32'h090A0B0C});
        exp_q.push_back('{a: 4'hC, d: 32'h0D0E0F10});
        chk_log("ovf", exp_q);
        chk("ovf_flag", o_overflow, 1);
        chk("ovf_hold", o_cpu_hold, 0);
        chk("ovf_count", 32'(o_word_count), 4);

        // Reset in the middle of a word.
        drive(1, 1, 0, 8'h00);
        drive(1, 0, 1, 8'hAA);
        drive(1, 0, 1, 8'hBB);
        drive(0, 0, 1, 8'hCC);
        chk("mrst_we", o_we, 0);
        chk("mrst_data", o_instr_data, 0);
        chk("mrst_addr", 32'(o_addr), 0);
        chk("mrst_hold", o_cpu_hold, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_overflow", o_overflow, 0);
        chk("mrst_count", 32'(o_word_count), 0);
        wlog.delete();
        drive(1, 1, 0, 8'h00);
        drive(1, 0, 1, 8'hDE);
        drive(1, 0, 1, 8'hAD);
        drive(1, 0, 1, 8'hBE);
        drive(1, 0, 1, 8'hEF);
        idle(2);
        exp_q.delete();
        exp_q.push_back('{a: 4'h0, d: 32'hDEADBEEF});
        chk_log("mrst", exp_q);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            r_v = ($urandom_range(0, 499) != 0);
            s_v = ($urandom_range(0, 39) == 0);
            v_v = ($urandom_range(0, 9) < 6);
            b_v = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            drive(r_v, s_v, v_v, b_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
